src_ctrl_seq: RTL and testbench
===============================

Name: src_ctrl_seq

Overview:
- Parametrised controller sequencer for the multistage polyphase upsampler.
- Generalises the fixed 8-state controller FSM. It owns its own tap, phase, stage and channel counters instead of taking pass/last flags from outside.
- Adds ready/valid handshakes towards the audio input bus and the output bus.
- Sits between the audio bus and the regfile/RAM/MAC datapath. It drives the datapath through `ostate`, the index buses and the MAC strobes.

Parameters:
- STAGES, 3: number of upsampler stages per channel, >=1.
- PHASES, 2: polyphase vectors per stage, i.e. the interpolation factor, >=1.
- TAPS, 16: MAC cycles per vector convolution, >=1.
- CHANNELS, 2: audio channels processed per frame, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- en  in  1  clock enable; while low, all state and counters hold
- in_valid  in  1  input sample available on audio bus
- in_ready  out  1  controller accepts input sample this cycle
- out_valid  out  1  output sample valid on output bus
- out_ready  in  1  downstream accepts output sample
- ostate  out  3  current state, encoded as below
- chan_idx  out  CW  current channel; CW = max(1, clog2(CHANNELS))
- stage_idx  out  SW  current stage; SW = max(1, clog2(STAGES))
- phase_idx  out  PW  current phase vector; PW = max(1, clog2(PHASES))
- tap_idx  out  TW  current tap in CONV; TW = max(1, clog2(TAPS))
- mac_init  out  1  high in LOAD_INIT
- mac_acc  out  1  high in CONV
- frame_done  out  1  one-cycle pulse at the end of a frame

Behaviour:
- State encoding:
  - ALLOC = 000
  - LOAD_INIT = 001
  - CONV = 010
  - LOAD_RES = 011
  - LOAD_ERR = 100
  - LOAD_OUT = 101
  - LOAD_IN = 110
  - PC_INC = 111
- Single registered state. All transitions and counter updates occur on posedge clk, and only when en=1.
- Reset (rst=0, sampled on clk, takes priority over en):
  - state goes to LOAD_IN; all index counters go to 0.
  - frame_done, out_valid and mac_* go low; in_ready goes high only once en=1.
  - Reset mid-operation abandons the frame; no output handshake completes.
- Output decodes (combinational from state):
  - in_ready = (state==LOAD_IN) & en
  - out_valid = (state==LOAD_OUT) & en
  - mac_init = (state==LOAD_INIT); mac_acc = (state==CONV)
- LOAD_IN: on in_valid & in_ready:
  - if chan_idx==CHANNELS-1: chan_idx, stage_idx and phase_idx go to 0 and the state goes to ALLOC.
  - otherwise chan_idx increments and the state stays in LOAD_IN.
  - Exactly CHANNELS input handshakes per frame.
- ALLOC goes to LOAD_INIT. LOAD_INIT goes to CONV with tap_idx=0.
- CONV:
  - tap_idx increments each enabled cycle.
  - at tap_idx==TAPS-1, tap_idx goes to 0 and the state goes to LOAD_RES.
  - CONV lasts exactly TAPS enabled cycles; with TAPS=1, a single CONV cycle.
- LOAD_RES goes to LOAD_ERR.
- LOAD_ERR goes to LOAD_OUT if stage_idx==STAGES-1, else to PC_INC.
- LOAD_OUT:
  - holds while out_ready=0; out_valid stays high and indices stay stable.
  - on out_valid & out_ready, goes to PC_INC.
- PC_INC advances in phase-inner, stage, then channel order:
  - phase_idx increments; on wrap, stage_idx increments; on stage wrap, chan_idx increments.
  - on channel wrap (all three at their maxima): all counters go to 0, frame_done=1 this cycle (only if en=1), next state is LOAD_IN.
  - otherwise, next state is ALLOC.
- Cycle count per vector: TAPS+5 enabled cycles, plus LOAD_OUT cycles on the last stage.
- Frame length with defaults and no stalls:
  - 2 LOAD_IN + 2 channels x (6 vectors x 21 + 2 LOAD_OUT) = 258 cycles.
- en=0 freezes everything, including counters, and masks the handshakes. A pending out_ready or in_valid is not consumed while en=0.
- Counters never exceed their parameter bound-1. With a parameter equal to 1, its counter stays 0.

Test Plan:
- Reset then defaults, in_valid=1, out_ready=1 -> two input accepts, then exactly 4 out_valid/out_ready handshakes. frame_done pulses once, 258 cycles after the first in_ready, and the state returns to LOAD_IN (110).
- Per-vector timing, STAGES=1, PHASES=1, TAPS=4, CHANNELS=1 -> state sequence 110, 000, 001, 010x4, 011, 100, 101, 111, 110. tap_idx goes 0,1,2,3 during CONV; mac_init is high for exactly 1 cycle.
- Output backpressure: hold out_ready=0 for 10 cycles in LOAD_OUT -> state stays 101 and out_valid=1 with stable chan/stage/phase. It advances to 111 one cycle after out_ready=1.
- Input starvation: in_valid=0 for 20 cycles after reset -> state stays 110, in_ready=1, and no datapath strobes.
- Clock-enable freeze: drop en for 5 cycles mid-CONV at tap_idx=7 -> tap_idx=7 is held and in_ready/out_valid stay 0. Counting resumes at 8.
- Reset mid-frame: assert rst=0 during stage 1, LOAD_ERR -> the next cycle is state 110 with all indices 0. No frame_done pulse; the next frame completes normally.

Source files
------------

// File: rtl/src_ctrl_seq.sv
// -----------------------------------------------------------------------------
// src_ctrl_seq
//
// Controller sequencer for the multistage polyphase upsampler. It accepts one
// sample per channel from the audio bus. For every channel, stage and phase it
// then walks the datapath through one vector convolution:
//   ALLOC -> LOAD_INIT -> CONV x TAPS -> LOAD_RES -> LOAD_ERR
//         -> [LOAD_OUT on the last stage] -> PC_INC
// Its own tap, phase, stage and channel counters index the regfile, RAM and
// MAC datapath.
//
// Ports
//   clk         clock
//   rst         synchronous reset, active low (takes priority over en)
//   en          clock enable; while low every register holds
//   in_valid    audio bus has a sample
//   in_ready    controller takes the sample this cycle (LOAD_IN & en)
//   out_valid   output bus sample valid (LOAD_OUT & en)
//   out_ready   downstream takes the output sample
//   ostate      current state, 3-bit encoding below
//   chan_idx    current channel
//   stage_idx   current upsampler stage
//   phase_idx   current polyphase vector
//   tap_idx     current tap while in CONV
//   mac_init    high in LOAD_INIT
//   mac_acc     high in CONV
//   frame_done  one-cycle pulse on the PC_INC that closes the frame
// -----------------------------------------------------------------------------
module src_ctrl_seq #(
  parameter int STAGES   = 3,
  parameter int PHASES   = 2,
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SW = (STAGES   > 1) ? $clog2(STAGES)   : 1,
  localparam int PW = (PHASES   > 1) ? $clog2(PHASES)   : 1,
  localparam int TW = (TAPS     > 1) ? $clog2(TAPS)     : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    ostate,
  output logic [CW-1:0] chan_idx,
  output logic [SW-1:0] stage_idx,
  output logic [PW-1:0] phase_idx,
  output logic [TW-1:0] tap_idx,
  output logic          mac_init,
  output logic          mac_acc,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    ST_ALLOC     = 3'b000,
    ST_LOAD_INIT = 3'b001,
    ST_CONV      = 3'b010,
    ST_LOAD_RES  = 3'b011,
    ST_LOAD_ERR  = 3'b100,
    ST_LOAD_OUT  = 3'b101,
    ST_LOAD_IN   = 3'b110,
    ST_PC_INC    = 3'b111
  } state_e;

  localparam logic [CW-1:0] CH_MAX  = CW'(CHANNELS - 1);
  localparam logic [SW-1:0] STG_MAX = SW'(STAGES - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(PHASES - 1);
  localparam logic [TW-1:0] TAP_MAX = TW'(TAPS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] chan_q,  chan_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] tap_q,   tap_d;

  // PC_INC of the last phase of the last stage of the last channel.
  logic last_vec;
  assign last_vec = (phase_q == PH_MAX) && (stage_q == STG_MAX) && (chan_q == CH_MAX);

  // ---------------------------------------------------------------------------
  // State and counter register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // sampled on clk (synchronous) and wins over en, so a frame in flight is
  // simply abandoned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOAD_IN;
      chan_q  <= '0;
      stage_q <= '0;
      phase_q <= '0;
      tap_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      chan_q  <= chan_d;
      stage_q <= stage_d;
      phase_q <= phase_d;
      tap_q   <= tap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold value first, so no path leaves a latch.
    state_d = state_q;
    chan_d  = chan_q;
    stage_d = stage_q;
    phase_d = phase_q;
    tap_d   = tap_q;

    case (state_q)
      ST_LOAD_IN: begin
        if (in_valid && in_ready) begin
          if (chan_q == CH_MAX) begin
            chan_d  = '0;
            stage_d = '0;
            phase_d = '0;
            state_d = ST_ALLOC;
          end else begin
            chan_d = chan_q + CW'(1);
          end
        end
      end

      ST_ALLOC: state_d = ST_LOAD_INIT;

      ST_LOAD_INIT: begin
        tap_d   = '0;
        state_d = ST_CONV;
      end

      ST_CONV: begin
        if (tap_q == TAP_MAX) begin
          tap_d   = '0;
          state_d = ST_LOAD_RES;
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end

      ST_LOAD_RES: state_d = ST_LOAD_ERR;

      // Only the final stage of a channel produces a sample for the output bus.
      ST_LOAD_ERR: state_d = (stage_q == STG_MAX) ? ST_LOAD_OUT : ST_PC_INC;

      ST_LOAD_OUT: begin
        if (out_valid && out_ready) state_d = ST_PC_INC;
      end

      // Phase is the innermost loop, then stage, then channel.
      ST_PC_INC: begin
        state_d = ST_ALLOC;
        if (phase_q != PH_MAX) begin
          phase_d = phase_q + PW'(1);
        end else begin
          phase_d = '0;
          if (stage_q != STG_MAX) begin
            stage_d = stage_q + SW'(1);
          end else begin
            stage_d = '0;
            if (chan_q != CH_MAX) begin
              chan_d = chan_q + CW'(1);
            end else begin
              chan_d  = '0;
              state_d = ST_LOAD_IN;
            end
          end
        end
      end

      default: state_d = ST_LOAD_IN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Both handshakes are masked by en so a frozen controller never consumes a
  // pending in_valid or out_ready.
  always_comb begin
    in_ready   = (state_q == ST_LOAD_IN)  && en;
    out_valid  = (state_q == ST_LOAD_OUT) && en;
    mac_init   = (state_q == ST_LOAD_INIT);
    mac_acc    = (state_q == ST_CONV);
    frame_done = (state_q == ST_PC_INC) && last_vec && en;
  end

  assign ostate    = state_q;
  assign chan_idx  = chan_q;
  assign stage_idx = stage_q;
  assign phase_idx = phase_q;
  assign tap_idx   = tap_q;

endmodule

// File: tb/tb_src_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_src_ctrl_seq
//
// Main DUT uses the default parameters. A behavioural model expands every frame
// into the ordered list of steps it must walk through. That list is a queue
// built from nested channel/stage/phase/tap loops. The step at the head of the
// queue gives the expected outputs for the current cycle. The head is consumed
// on an enabled cycle unless it is a handshake step whose partner signal is low.
// A second, minimal DUT (1 stage, 1 phase, 4 taps, 1 channel) is pinned
// against a hand-written state sequence.
// -----------------------------------------------------------------------------
module tb_src_ctrl_seq;

  localparam int STAGES   = 3;
  localparam int PHASES   = 2;
  localparam int TAPS     = 16;
  localparam int CHANNELS = 2;
  localparam int CW = 1, SW = 2, PW = 1, TW = 4;

  localparam logic [2:0] S_ALLOC = 3'b000, S_INIT = 3'b001, S_CONV = 3'b010,
                         S_RES   = 3'b011, S_ERR  = 3'b100, S_OUT  = 3'b101,
                         S_IN    = 3'b110, S_INC  = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, in_valid, out_ready;
  logic in_ready, out_valid, mac_init, mac_acc, frame_done;
  logic [2:0]    ostate;
  logic [CW-1:0] chan_idx;
  logic [SW-1:0] stage_idx;
  logic [PW-1:0] phase_idx;
  logic [TW-1:0] tap_idx;

  src_ctrl_seq #(.STAGES(STAGES), .PHASES(PHASES), .TAPS(TAPS), .CHANNELS(CHANNELS)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ostate(ostate), .chan_idx(chan_idx), .stage_idx(stage_idx),
    .phase_idx(phase_idx), .tap_idx(tap_idx),
    .mac_init(mac_init), .mac_acc(mac_acc), .frame_done(frame_done)
  );

  // Minimal configuration, always enabled, never stalled.
  logic       hi;
  logic       in_ready2, out_valid2, mac_init2, mac_acc2, frame_done2;
  logic [2:0] ostate2;
  logic       chan2, stage2, phase2;
  logic [1:0] tap2;
  assign hi = 1'b1;

  src_ctrl_seq #(.STAGES(1), .PHASES(1), .TAPS(4), .CHANNELS(1)) u_small (
    .clk(clk), .rst(rst), .en(hi),
    .in_valid(hi), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(hi),
    .ostate(ostate2), .chan_idx(chan2), .stage_idx(stage2),
    .phase_idx(phase2), .tap_idx(tap2),
    .mac_init(mac_init2), .mac_acc(mac_acc2), .frame_done(frame_done2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d at %0t", nm, act, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a frame is an ordered list of steps
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0] st;
    int         c, s, p, t;
    bit         last;
  } step_t;

  step_t sched[$];
  bit    model_ok = 1'b0;

  function automatic void push(logic [2:0] st, int c, int s, int p, int t, bit last);
    step_t e;
    e.st = st; e.c = c; e.s = s; e.p = p; e.t = t; e.last = last;
    sched.push_back(e);
  endfunction

  function automatic void build_frame();
    for (int c = 0; c < CHANNELS; c++) push(S_IN, c, 0, 0, 0, 1'b0);
    for (int c = 0; c < CHANNELS; c++)
      for (int s = 0; s < STAGES; s++)
        for (int p = 0; p < PHASES; p++) begin
          push(S_ALLOC, c, s, p, 0, 1'b0);
          push(S_INIT,  c, s, p, 0, 1'b0);
          for (int t = 0; t < TAPS; t++) push(S_CONV, c, s, p, t, 1'b0);
          push(S_RES, c, s, p, 0, 1'b0);
          push(S_ERR, c, s, p, 0, 1'b0);
          if (s == STAGES - 1) push(S_OUT, c, s, p, 0, 1'b0);
          push(S_INC, c, s, p, 0, (c == CHANNELS-1) && (s == STAGES-1) && (p == PHASES-1));
        end
  endfunction

  // Compare on the falling edge; inputs only change just after the rising
  // edge, so the values seen here are the ones the next rising edge will use.
  always @(negedge clk) begin
    step_t h;
    bit    adv;
    if (model_ok) begin
      h = sched[0];
      check("ostate",     ostate,     h.st);
      check("chan_idx",   chan_idx,   h.c);
      check("stage_idx",  stage_idx,  h.s);
      check("phase_idx",  phase_idx,  h.p);
      check("tap_idx",    tap_idx,    h.t);
      check("in_ready",   in_ready,   (h.st == S_IN)  && en);
      check("out_valid",  out_valid,  (h.st == S_OUT) && en);
      check("mac_init",   mac_init,   h.st == S_INIT);
      check("mac_acc",    mac_acc,    h.st == S_CONV);
      check("frame_done", frame_done, h.last && en);
    end
    if (rst === 1'b0) begin
      sched.delete();
      build_frame();
      model_ok = 1'b1;
    end else if (model_ok && en) begin
      adv = 1'b1;
      if (h.st == S_IN  && !in_valid)  adv = 1'b0;
      if (h.st == S_OUT && !out_ready) adv = 1'b0;
      if (adv) begin
        void'(sched.pop_front());
        if (sched.size() == 0) build_frame();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Minimal configuration: literal state/tap sequence after the first reset
  // ---------------------------------------------------------------------------
  localparam logic [2:0] SM_ST [12] = '{S_IN, S_ALLOC, S_INIT, S_CONV, S_CONV, S_CONV,
                                        S_CONV, S_RES, S_ERR, S_OUT, S_INC, S_IN};
  localparam logic [1:0] SM_TAP [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2,
                                         2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  initial begin : small_seq
    int n_init;
    n_init = 0;
    @(posedge rst);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("small_state", ostate2, SM_ST[i]);
      check("small_tap",   tap2,    SM_TAP[i]);
      check("small_idx",   {chan2, stage2, phase2}, 3'b000);
      check("small_frame_done", frame_done2, i == 10);
      check("small_out_valid",  out_valid2,  i == 9);
      check("small_in_ready",   in_ready2,   (i == 0) || (i == 11));
      if (mac_init2) n_init++;
      if (i >= 3 && i <= 6) check("small_mac_acc", mac_acc2, 1'b1);
    end
    check("small_mac_init_cycles", n_init, 1);
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic run_frame(output int len, output int n_in, output int n_out, output int n_fd);
    int first_ir, fd_cyc;
    first_ir = -1; fd_cyc = -1; n_in = 0; n_out = 0; n_fd = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (in_ready && first_ir < 0) first_ir = k;
      if (in_ready && in_valid)     n_in++;
      if (out_valid && out_ready)   n_out++;
      if (frame_done) begin
        n_fd++;
        fd_cyc = k;
        break;
      end
    end
    len = fd_cyc - first_ir + 1;
    @(posedge clk); #1;
  endtask

  initial begin : main
    int  len, n_in, n_out, n_fd;
    bit  found;
    logic [CW-1:0] c0;
    logic [SW-1:0] s0;
    logic [PW-1:0] p0;

    rst = 1'b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Full frame, no stalls.
    run_frame(len, n_in, n_out, n_fd);
    check("frame_len_cycles", len, 258);
    check("frame_in_hs",      n_in, 2);
    check("frame_out_hs",     n_out, 4);
    check("frame_done_count", n_fd, 1);
    check("frame_end_state",  ostate, S_IN);

    // Input starvation after reset.
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("starve_state",    ostate, S_IN);
      check("starve_in_ready", in_ready, 1'b1);
      check("starve_strobes",  {mac_init, mac_acc, out_valid, frame_done}, 4'b0000);
    end

    // Output backpressure.
    in_valid = 1'b1; out_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk); #1;
      if (ostate == S_OUT) found = 1'b1;
    end
    check("reach_load_out", found, 1'b1);
    c0 = chan_idx; s0 = stage_idx; p0 = phase_idx;
    check("load_out_stage", s0, STAGES - 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_state",     ostate, S_OUT);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_indices",   {chan_idx, stage_idx, phase_idx}, {c0, s0, p0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_state", ostate, S_INC);

    // Clock-enable freeze mid-CONV at tap 7.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk); #1;
      if (ostate == S_CONV && tap_idx == 4'd7) found = 1'b1;
    end
    check("reach_tap7", found, 1'b1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("freeze_tap",   tap_idx, 4'd7);
      check("freeze_state", ostate, S_CONV);
      check("freeze_hs",    {in_ready, out_valid}, 2'b00);
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("resume_tap", tap_idx, 4'd8);

    // Reset during stage 1, LOAD_ERR.
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(posedge clk); #1;
      if (ostate == S_ERR && stage_idx == 2'd1) found = 1'b1;
    end
    check("reach_err_stage1", found, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_state",   ostate, S_IN);
    check("rst_indices", {chan_idx, stage_idx, phase_idx, tap_idx}, '0);
    check("rst_no_done", frame_done, 1'b0);
    rst = 1'b1;
    run_frame(len, n_in, n_out, n_fd);
    check("post_rst_frame_len", len, 258);
    check("post_rst_out_hs",    n_out, 4);
    check("post_rst_done",      n_fd, 1);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 5000; k++) begin
      en        = ($urandom_range(9) != 0);
      in_valid  = ($urandom_range(2) != 0);
      out_ready = ($urandom_range(1) != 0);
      rst       = ($urandom_range(1999) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
